// File: rtl/ram_wr_arbiter.sv
// rtl/ram_wr_arbiter.sv - CPU/peripheral arbiter for the shared RAM/SFR write port
module ram_wr_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_wr_en,
  input  logic [ADDR_W-1:0] cpu_wr_addr,
  input  logic [DATA_W-1:0] cpu_wr_byte,
  output logic              cpu_stall,
  input  logic              per_wr_req,
  input  logic [ADDR_W-1:0] per_wr_addr,
  input  logic [DATA_W-1:0] per_wr_byte,
  output logic              per_wr_ready,
  output logic              ram_wr_en_data,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_byte,
  output logic              squash,
  output logic              drop_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [DEPTH-1:0]  fifo_valid;
  logic [DEPTH-1:0]  valid_next;
  logic [DEPTH-1:0]  squash_vec;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [STV_W-1:0]  starve_cnt;

  logic fifo_empty;
  logic head_valid;
  logic issue_cpu;
  logic issue_per;
  logic push;
  logic pop;
  logic push_hit;

  // Ready and stall are pure decodes of registers so they never depend on same-cycle pops.
  assign fifo_empty   = (count == '0);
  assign per_wr_ready = (count != CNT_W'(DEPTH));
  assign cpu_stall    = (starve_cnt == STV_W'(STARVE_LIMIT));
  assign head_valid   = !fifo_empty && fifo_valid[rd_ptr];

  // A stalled CPU write is never taken; the head wins whenever it is valid and the CPU is not issuing.
  assign issue_cpu = cpu_wr_en && !cpu_stall;
  assign issue_per = head_valid && (cpu_stall || !cpu_wr_en);

  // Invalidated heads drain one per cycle alongside anything else.
  assign pop      = !fifo_empty && (!fifo_valid[rd_ptr] || issue_per);
  assign push     = per_wr_req && per_wr_ready;
  assign push_hit = push && issue_cpu && (per_wr_addr == cpu_wr_addr);

  // Match the issued CPU address against every valid entry and build the next valid vector.
  always_comb begin
    squash_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      squash_vec[i] = issue_cpu && fifo_valid[i] && (fifo_addr[i] == cpu_wr_addr);
    end
    valid_next = fifo_valid & ~squash_vec;
    if (pop) begin
      valid_next[rd_ptr] = 1'b0;
    end
    if (push) begin
      valid_next[wr_ptr] = !push_hit;
    end
  end

  // FIFO pointers, occupancy and valid bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      fifo_valid <= '0;
    end else begin
      fifo_valid <= valid_next;
      count      <= count + CNT_W'(push) - CNT_W'(pop);
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  // FIFO payload storage; contents are only meaningful where the valid bit is set.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr[wr_ptr] <= per_wr_addr;
      fifo_data[wr_ptr] <= per_wr_byte;
    end
  end

  // Count consecutive CPU-occupied cycles that leave a valid head waiting.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (issue_per || fifo_empty) begin
      starve_cnt <= '0;
    end else if (head_valid && issue_cpu && !cpu_stall) begin
      starve_cnt <= starve_cnt + STV_W'(1);
    end
  end

  // Register the selected write and the status pulses onto the RAM side.
  always_ff @(posedge clock) begin
    if (reset) begin
      ram_wr_en_data <= 1'b0;
      ram_wr_addr    <= '0;
      ram_wr_byte    <= '0;
      squash         <= 1'b0;
      drop_err       <= 1'b0;
    end else begin
      ram_wr_en_data <= issue_cpu || issue_per;
      squash         <= (|squash_vec) || push_hit;
      drop_err       <= cpu_wr_en && cpu_stall;
      if (issue_per) begin
        ram_wr_addr <= fifo_addr[rd_ptr];
        ram_wr_byte <= fifo_data[rd_ptr];
      end else if (issue_cpu) begin
        ram_wr_addr <= cpu_wr_addr;
        ram_wr_byte <= cpu_wr_byte;
      end
    end
  end

endmodule

// File: tb/tb_ram_wr_arbiter.sv
// tb/tb_ram_wr_arbiter.sv - directed self-checking bench for ram_wr_arbiter
module tb_ram_wr_arbiter;

  logic       clock;
  logic       reset;
  logic       cpu_wr_en;
  logic [7:0] cpu_wr_addr;
  logic [7:0] cpu_wr_byte;
  logic       cpu_stall;
  logic       per_wr_req;
  logic [7:0] per_wr_addr;
  logic [7:0] per_wr_byte;
  logic       per_wr_ready;
  logic       ram_wr_en_data;
  logic [7:0] ram_wr_addr;
  logic [7:0] ram_wr_byte;
  logic       squash;
  logic       drop_err;

  int checks;
  int failures;

  ram_wr_arbiter #(
    .DEPTH(4), .STARVE_LIMIT(8), .ADDR_W(8), .DATA_W(8)
  ) dut (
    .clock(clock), .reset(reset),
    .cpu_wr_en(cpu_wr_en), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_byte(cpu_wr_byte),
    .cpu_stall(cpu_stall),
    .per_wr_req(per_wr_req), .per_wr_addr(per_wr_addr), .per_wr_byte(per_wr_byte),
    .per_wr_ready(per_wr_ready),
    .ram_wr_en_data(ram_wr_en_data), .ram_wr_addr(ram_wr_addr), .ram_wr_byte(ram_wr_byte),
    .squash(squash), .drop_err(drop_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_wr_en   = 1'b0;
    cpu_wr_addr = 8'h00;
    cpu_wr_byte = 8'h00;
    per_wr_req  = 1'b0;
    per_wr_addr = 8'h00;
    per_wr_byte = 8'h00;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({ram_wr_en_data, ram_wr_addr, ram_wr_byte, squash, drop_err, cpu_stall} !== 20'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0",
               {ram_wr_en_data, ram_wr_addr, ram_wr_byte, squash, drop_err, cpu_stall});
    end
    checks++;
    if (per_wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", per_wr_ready);
    end
    cpu_wr_en = 1'b1; cpu_wr_addr = 8'h81; cpu_wr_byte = 8'h55;
    tick();
    cpu_wr_en = 1'b0;
    checks++;
    if ({ram_wr_en_data, ram_wr_addr, ram_wr_byte} !== {1'b1, 8'h81, 8'h55}) begin
      failures++;
      $display("FAIL cpu_write got=%h exp=%h", {ram_wr_en_data, ram_wr_addr, ram_wr_byte}, {1'b1, 8'h81, 8'h55});
    end
    checks++;
    if ({squash, drop_err, cpu_stall, per_wr_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL cpu_write_flags got=%b exp=0001", {squash, drop_err, cpu_stall, per_wr_ready});
    end
    tick();
    checks++;
    if ({ram_wr_en_data, ram_wr_addr, ram_wr_byte} !== {1'b0, 8'h81, 8'h55}) begin
      failures++;
      $display("FAIL cpu_write_hold got=%h exp=%h", {ram_wr_en_data, ram_wr_addr, ram_wr_byte}, {1'b0, 8'h81, 8'h55});
    end
  endtask

  task automatic test_fifo_order();
    per_wr_req = 1'b1; per_wr_addr = 8'h8A; per_wr_byte = 8'h01;
    tick();
    checks++;
    if (ram_wr_en_data !== 1'b0) begin
      failures++;
      $display("FAIL no_bypass got=%b exp=0", ram_wr_en_data);
    end
    per_wr_addr = 8'h8C; per_wr_byte = 8'h02;
    tick();
    per_wr_req = 1'b0;
    checks++;
    if ({ram_wr_en_data, ram_wr_addr, ram_wr_byte} !== {1'b1, 8'h8A, 8'h01}) begin
      failures++;
      $display("FAIL per_first got=%h exp=%h", {ram_wr_en_data, ram_wr_addr, ram_wr_byte}, {1'b1, 8'h8A, 8'h01});
    end
    tick();
    checks++;
    if ({ram_wr_en_data, ram_wr_addr, ram_wr_byte} !== {1'b1, 8'h8C, 8'h02}) begin
      failures++;
      $display("FAIL per_second got=%h exp=%h", {ram_wr_en_data, ram_wr_addr, ram_wr_byte}, {1'b1, 8'h8C, 8'h02});
    end
    tick();
    checks++;
    if ({ram_wr_en_data, per_wr_ready} !== 2'b01) begin
      failures++;
      $display("FAIL per_drained got=%b exp=01", {ram_wr_en_data, per_wr_ready});
    end
  endtask

  task automatic test_starvation();
    for (int n = 0; n < 9; n++) begin
      cpu_wr_en   = 1'b1;
      cpu_wr_addr = 8'h20 + 8'(n);
      cpu_wr_byte = 8'(n);
      per_wr_req  = (n < 5);
      per_wr_addr = 8'h90 + 8'(n);
      per_wr_byte = 8'hA0 + 8'(n);
      checks++;
      if (cpu_stall !== 1'b0) begin
        failures++;
        $display("FAIL early_stall cycle=%0d got=%b exp=0", n, cpu_stall);
      end
      checks++;
      if (per_wr_ready !== (n < 4)) begin
        failures++;
        $display("FAIL fill_ready cycle=%0d got=%b exp=%b", n, per_wr_ready, (n < 4));
      end
      tick();
      checks++;
      if ({ram_wr_en_data, ram_wr_addr, ram_wr_byte} !== {1'b1, 8'h20 + 8'(n), 8'(n)}) begin
        failures++;
        $display("FAIL busy_cpu cycle=%0d got=%h exp=%h", n,
                 {ram_wr_en_data, ram_wr_addr, ram_wr_byte}, {1'b1, 8'h20 + 8'(n), 8'(n)});
      end
    end
    per_wr_req = 1'b0;
    cpu_wr_en = 1'b1; cpu_wr_addr = 8'h29; cpu_wr_byte = 8'h09;
    checks++;
    if (cpu_stall !== 1'b1) begin
      failures++;
      $display("FAIL stall_asserted got=%b exp=1", cpu_stall);
    end
    tick();
    cpu_wr_en = 1'b0;
    checks++;
    if ({ram_wr_en_data, ram_wr_addr, ram_wr_byte} !== {1'b1, 8'h90, 8'hA0}) begin
      failures++;
      $display("FAIL forced_slot got=%h exp=%h", {ram_wr_en_data, ram_wr_addr, ram_wr_byte}, {1'b1, 8'h90, 8'hA0});
    end
    checks++;
    if ({drop_err, cpu_stall} !== 2'b10) begin
      failures++;
      $display("FAIL drop_err got=%b exp=10", {drop_err, cpu_stall});
    end
    for (int k = 1; k < 4; k++) begin
      tick();
      checks++;
      if ({ram_wr_en_data, ram_wr_addr, ram_wr_byte, drop_err} !== {1'b1, 8'h90 + 8'(k), 8'hA0 + 8'(k), 1'b0}) begin
        failures++;
        $display("FAIL drain entry=%0d got=%h exp=%h", k,
                 {ram_wr_en_data, ram_wr_addr, ram_wr_byte, drop_err}, {1'b1, 8'h90 + 8'(k), 8'hA0 + 8'(k), 1'b0});
      end
    end
    tick();
    checks++;
    if (ram_wr_en_data !== 1'b0) begin
      failures++;
      $display("FAIL fifth_not_acked got=%b exp=0", ram_wr_en_data);
    end
  endtask

  task automatic test_squash_pending();
    per_wr_req = 1'b1; per_wr_addr = 8'h88; per_wr_byte = 8'h20;
    cpu_wr_en = 1'b1; cpu_wr_addr = 8'h30; cpu_wr_byte = 8'h11;
    tick();
    per_wr_req = 1'b0;
    checks++;
    if ({ram_wr_en_data, ram_wr_addr, ram_wr_byte, squash} !== {1'b1, 8'h30, 8'h11, 1'b0}) begin
      failures++;
      $display("FAIL sq_setup got=%h exp=%h", {ram_wr_en_data, ram_wr_addr, ram_wr_byte, squash}, {1'b1, 8'h30, 8'h11, 1'b0});
    end
    cpu_wr_addr = 8'h88; cpu_wr_byte = 8'h00;
    tick();
    cpu_wr_en = 1'b0;
    checks++;
    if ({ram_wr_en_data, ram_wr_addr, ram_wr_byte, squash} !== {1'b1, 8'h88, 8'h00, 1'b1}) begin
      failures++;
      $display("FAIL sq_pending got=%h exp=%h", {ram_wr_en_data, ram_wr_addr, ram_wr_byte, squash}, {1'b1, 8'h88, 8'h00, 1'b1});
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({ram_wr_en_data, ram_wr_addr, ram_wr_byte, squash} !== {1'b0, 8'h88, 8'h00, 1'b0}) begin
        failures++;
        $display("FAIL sq_silent_pop step=%0d got=%h exp=%h", k,
                 {ram_wr_en_data, ram_wr_addr, ram_wr_byte, squash}, {1'b0, 8'h88, 8'h00, 1'b0});
      end
    end
  endtask

  task automatic test_squash_same_cycle();
    per_wr_req = 1'b1; per_wr_addr = 8'h88; per_wr_byte = 8'hFF;
    cpu_wr_en = 1'b1; cpu_wr_addr = 8'h88; cpu_wr_byte = 8'h00;
    checks++;
    if (per_wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL sq_push_acked got=%b exp=1", per_wr_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if ({ram_wr_en_data, ram_wr_addr, ram_wr_byte, squash} !== {1'b1, 8'h88, 8'h00, 1'b1}) begin
      failures++;
      $display("FAIL sq_same got=%h exp=%h", {ram_wr_en_data, ram_wr_addr, ram_wr_byte, squash}, {1'b1, 8'h88, 8'h00, 1'b1});
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({ram_wr_en_data, ram_wr_addr, ram_wr_byte, squash} !== {1'b0, 8'h88, 8'h00, 1'b0}) begin
        failures++;
        $display("FAIL sq_same_nowrite step=%0d got=%h exp=%h", k,
                 {ram_wr_en_data, ram_wr_addr, ram_wr_byte, squash}, {1'b0, 8'h88, 8'h00, 1'b0});
      end
    end
  endtask

  task automatic test_reset_pending();
    for (int n = 0; n < 3; n++) begin
      cpu_wr_en = 1'b1; cpu_wr_addr = 8'h40 + 8'(n); cpu_wr_byte = 8'h70;
      per_wr_req = 1'b1; per_wr_addr = 8'hB0 + 8'(n); per_wr_byte = 8'hE0;
      tick();
    end
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({ram_wr_en_data, ram_wr_addr, ram_wr_byte, squash, drop_err, cpu_stall, per_wr_ready} !== 21'h1) begin
      failures++;
      $display("FAIL rst_pending_outputs got=%h exp=1",
               {ram_wr_en_data, ram_wr_addr, ram_wr_byte, squash, drop_err, cpu_stall, per_wr_ready});
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (ram_wr_en_data !== 1'b0) begin
        failures++;
        $display("FAIL rst_discard step=%0d got=%b exp=0", k, ram_wr_en_data);
      end
    end
    for (int n = 0; n < 4; n++) begin
      cpu_wr_en = 1'b1; cpu_wr_addr = 8'h50 + 8'(n); cpu_wr_byte = 8'h33;
      per_wr_req = 1'b1; per_wr_addr = 8'hC0 + 8'(n); per_wr_byte = 8'hD0;
      tick();
      checks++;
      if (per_wr_ready !== (n < 3)) begin
        failures++;
        $display("FAIL rst_count_empty push=%0d got=%b exp=%b", n, per_wr_ready, (n < 3));
      end
    end
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    idle_inputs();
    test_reset();
    test_fifo_order();
    test_starvation();
    test_squash_pending();
    test_squash_same_cycle();
    test_reset_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_wr_arbiter.md
Name: ram_wr_arbiter

Overview:
Shares the single internal-RAM/SFR write port between the CPU datapath and peripheral writers such as the timer (TL0/TH0/TCON updates). CPU writes have priority and are issued directly. Peripheral writes are buffered in a small FIFO and drained into idle write slots. A starvation counter forces one peripheral slot, stalling the CPU, when the CPU keeps the port busy too long. The block sits between datapath/timer and the ram write port.

Parameters:
DEPTH, 4, peripheral FIFO entries (power of 2, >=2)
STARVE_LIMIT, 8, consecutive CPU-occupied cycles with a valid FIFO head before a forced peripheral slot
ADDR_W, 8, RAM/SFR address width
DATA_W, 8, data width

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
cpu_wr_en  in  1  CPU write request, single cycle
cpu_wr_addr  in  ADDR_W  CPU write address
cpu_wr_byte  in  DATA_W  CPU write data
cpu_stall  out  1  forced peripheral slot this cycle; CPU write is not taken
per_wr_req  in  1  peripheral write request
per_wr_addr  in  ADDR_W  peripheral write address
per_wr_byte  in  DATA_W  peripheral write data
per_wr_ready  out  1  FIFO can accept; a push happens when req && ready
ram_wr_en_data  out  1  registered write strobe to ram
ram_wr_addr  out  ADDR_W  registered write address
ram_wr_byte  out  DATA_W  registered write data
squash  out  1  registered pulse: one or more peripheral entries invalidated this cycle
drop_err  out  1  registered pulse: cpu_wr_en was asserted while cpu_stall=1

Behaviour:
- Reset, synchronous: all outputs 0 except per_wr_ready, which is 1 after the reset cycle. FIFO is emptied, all valid bits cleared, starve_cnt=0. Pending entries are discarded with no write. Reset wins over every other event.
- The FIFO holds {addr, data, valid}. count includes invalid entries. per_wr_ready = (count != DEPTH). It is computed from registers only, so there is no push at full even when a pop occurs in the same cycle.
- cpu_stall = (starve_cnt == STARVE_LIMIT). It is a decode of a register.
- Per-cycle slot selection, in priority order:
  1. cpu_stall=1 and the head is valid: issue the head, pop it, clear starve_cnt. If cpu_wr_en=1, the CPU write is discarded and drop_err=1 next cycle.
  2. cpu_wr_en=1: issue the CPU write.
  3. The head is valid: issue the head and pop it.
  4. Otherwise: no write.
- Invalid head: it is popped silently in any cycle, one per cycle, in parallel with a CPU write. No RAM write is produced for it.
- Issued write: it is registered onto ram_wr_*, with ram_wr_en_data=1 in the following cycle. When no write is issued, ram_wr_en_data=0 and addr/byte hold their previous values.
- Latency:
  - CPU write in cycle k -> ram_wr_en_data in cycle k+1.
  - Peripheral push in cycle k into an idle, empty FIFO -> ram_wr_en_data in cycle k+2. There is no bypass.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, in each cycle where the head is valid and a CPU write is issued.
  - Clears when the head is issued or the FIFO is empty.
  - Holds otherwise.
- Squash: an issued CPU write to address A clears valid on every FIFO entry with addr==A. It also clears valid on a same-cycle accepted push with addr==A, which is still acked. squash=1 next cycle if any entry was invalidated. This keeps CPU writes (e.g. clearing TF0) from being overwritten by older peripheral updates.
- Squash does not apply to a CPU write discarded under cpu_stall.
- Simultaneous push and pop when not full: both occur, and count is unchanged.
- Pointers wrap modulo DEPTH.
- FIFO order is strictly preserved among valid entries.

Test Plan:
1. Reset, then a CPU write (0x81, 0x55) in cycle 1 -> ram_wr_en_data=1, addr 0x81, byte 0x55 in cycle 2; per_wr_ready=1; all other outputs 0.
2. Idle CPU, peripheral pushes (0x8A,0x01), (0x8C,0x02) in consecutive cycles -> writes appear in cycles push+2 in the same order; FIFO returns to empty.
3. Push 4 entries while the CPU writes every cycle -> per_wr_ready=0 after the 4th push; a 5th req is not acked. After STARVE_LIMIT=8 CPU cycles, cpu_stall=1 for one cycle and the head is written. A CPU write during that cycle gives drop_err=1 and is absent from the RAM port.
4. Pending FIFO entry (0x88,0x20); CPU writes (0x88,0x00) -> squash=1; only the CPU write reaches RAM; the invalid head pops without a write.
5. Same-cycle push (0x88,0xFF) and CPU write (0x88,0x00) -> push acked, squash=1, only 0x00 is written.
6. Reset asserted with 3 entries pending -> no further writes; count=0; per_wr_ready=1 after reset.
